// File: rtl/threshold_fetch_ctrl_if.sv
// Controller-side bundle: sequence request, threshold ROM read port and comparator stream.
// master = controller, slave = requester / ROM / comparator side.
interface threshold_fetch_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [ADDR_WIDTH:0]   thre_num;
    logic                  clear;
    logic                  rom_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  thre_valid;
    logic                  thre_ready;
    logic [DATA_WIDTH-1:0] thre_data;
    logic                  thre_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, thre_num, clear, rom_data, thre_ready,
        output rom_en, rom_addr, thre_valid, thre_data, thre_last, busy, done
    );

    modport slave (
        output start, thre_num, clear, rom_data, thre_ready,
        input  rom_en, rom_addr, thre_valid, thre_data, thre_last, busy, done
    );
endinterface

// File: rtl/threshold_fetch_ctrl.sv
// Fetches thre_num words from a 1-cycle ROM into a small output buffer (2 entries with THRE_FIFO2_EN, else 1 register).
// First valid 2 cycles after start; reads issue only when the buffer can absorb them, so thre_ready backpressure never drops data.
module threshold_fetch_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input logic                    clk,
    input logic                    rst_n,
    threshold_fetch_ctrl_if.master tf
);

`ifdef THRE_FIFO2_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    localparam logic [ADDR_WIDTH:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH:0]   num_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rd_q;
    logic                  rd_last_q;
    logic                  hd_vld;
    logic                  hd_last;
    logic [DATA_WIDTH-1:0] hd_dat;
    logic [1:0]            occ;
    logic                  pop;
    logic                  push;
    logic                  can_issue;
    logic                  issue;
    logic                  last_issue;

    assign pop  = hd_vld & tf.thre_ready;
    assign push = rd_q;

    // A word popped this cycle frees its slot in time for a read issued now (data lands two edges later).
    assign can_issue  = ({1'b0, occ} + {2'b0, rd_q}) < (3'(CAP) + {2'b0, pop});
    assign issue      = (state == FETCH) && can_issue && !tf.clear;
    assign last_issue = ({1'b0, addr_q} == (num_q - ONE));

    assign tf.rom_en     = issue;
    assign tf.rom_addr   = addr_q;
    assign tf.busy       = (state != IDLE);
    assign tf.done       = (state == DONE);
    assign tf.thre_valid = hd_vld;
    assign tf.thre_data  = hd_dat;
    assign tf.thre_last  = hd_vld & hd_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            num_q     <= '0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            rd_last_q <= 1'b0;
        end else if (tf.clear) begin
            state     <= IDLE;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            rd_q      <= issue;
            rd_last_q <= issue & last_issue;
            case (state)
                IDLE: begin
                    if (tf.start) begin
                        num_q  <= tf.thre_num;
                        addr_q <= '0;
                        state  <= (tf.thre_num == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    // Address holds on the final read so it never wraps past the ROM top.
                    if (issue) begin
                        if (last_issue) state <= DRAIN;
                        else            addr_q <= addr_q + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (pop && hd_last) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef THRE_FIFO2_EN
    logic                  sk_vld;
    logic                  sk_last;
    logic [DATA_WIDTH-1:0] sk_dat;

    assign occ = {1'b0, hd_vld} + {1'b0, sk_vld};

    // Head register drives the stream; the second slot only fills while the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd_vld  <= 1'b0;
            hd_last <= 1'b0;
            hd_dat  <= '0;
            sk_vld  <= 1'b0;
            sk_last <= 1'b0;
            sk_dat  <= '0;
        end else if (tf.clear) begin
            hd_vld <= 1'b0;
            sk_vld <= 1'b0;
        end else if (pop) begin
            if (sk_vld) begin
                hd_dat  <= sk_dat;
                hd_last <= sk_last;
                sk_vld  <= push;
                if (push) begin
                    sk_dat  <= tf.rom_data;
                    sk_last <= rd_last_q;
                end
            end else if (push) begin
                hd_dat  <= tf.rom_data;
                hd_last <= rd_last_q;
            end else begin
                hd_vld <= 1'b0;
            end
        end else if (push) begin
            if (hd_vld) begin
                sk_dat  <= tf.rom_data;
                sk_last <= rd_last_q;
                sk_vld  <= 1'b1;
            end else begin
                hd_dat  <= tf.rom_data;
                hd_last <= rd_last_q;
                hd_vld  <= 1'b1;
            end
        end
    end
`else
    assign occ = {1'b0, hd_vld};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd_vld  <= 1'b0;
            hd_last <= 1'b0;
            hd_dat  <= '0;
        end else if (tf.clear) begin
            hd_vld <= 1'b0;
        end else if (push) begin
            hd_dat  <= tf.rom_data;
            hd_last <= rd_last_q;
            hd_vld  <= 1'b1;
        end else if (pop) begin
            hd_vld <= 1'b0;
        end
    end
`endif

endmodule
